// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad digit capture block.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // Column lines idle high; also the "no key" column pattern.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Indexed [row][col], col 0 = leftmost = cols[0].
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic one_low(input logic [3:0] pat);
        return ($countones(~pat) == 1);
    endfunction

endpackage

// File: rtl/keypad_digit_capture_if.sv
// Keypad matrix lines and captured-digit outputs of keypad_digit_capture.
interface keypad_digit_capture_if;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;

    modport master (
        input  cols,
        output rows,
        output digit_new,
        output digit_old,
        output key_valid
    );

    modport slave (
        output cols,
        input  rows,
        input  digit_new,
        input  digit_old,
        input  key_valid
    );
endinterface

// File: rtl/keypad_decode.sv
// Combinational lookup: row index plus one-hot-low column pattern to hex key value.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [3:0] col_pat,
    output logic [3:0] value
);

    logic [1:0] col_idx;
    logic       col_ok;

    always_comb begin
        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (col_pat)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    assign value = col_ok ? KEY_MAP[row_idx][col_idx] : 4'h0;

endmodule

// File: rtl/keypad_digit_capture.sv
// 4x4 keypad scanner with press/release debounce feeding a two-digit history.
// Optional held-key auto-repeat is enabled with `define KEYPAD_AUTO_REPEAT_EN.
module keypad_digit_capture
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4096,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_CYCLES   = 1048576
)
(
    input  logic                   clk,
    input  logic                   reset,
    keypad_digit_capture_if.master kp
);

    localparam int MAX_A   = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0]       cols_p0;
    logic [3:0]       csync;
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [3:0]       key_value;
    logic [3:0]       digit_new_q, digit_old_q;
    logic             key_valid_q;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

    // Stage p0/p1: two-flop synchronizer on the asynchronous column lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_p0 <= ROW_IDLE;
            csync   <= ROW_IDLE;
        end else begin
            cols_p0 <= kp.cols;
            csync   <= cols_p0;
        end
    end

    // Scan/debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            pat_q   <= ROW_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
        rpt_d   = '0;
`endif
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    // Exactly one low column is a candidate; none or several just move on.
                    if (one_low(csync)) begin
                        pat_d   = csync;
                        state_d = PRESS_DB;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (csync != pat_q) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    accept  = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (csync == ROW_IDLE) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
`ifdef KEYPAD_AUTO_REPEAT_EN
                else if (rpt_q == RPT_LAST) begin
                    accept = 1'b1;
                end else begin
                    rpt_d = rpt_q + CNT_ONE;
                end
`endif
            end
            RELEASE_DB: begin
                // A low bit here is contact bounce of the held key, not a new press.
                if (csync != ROW_IDLE) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    keypad_decode u_decode (
        .row_idx (row_q),
        .col_pat (pat_q),
        .value   (key_value)
    );

    // Output stage: digit history shift and single-cycle valid strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                digit_old_q <= digit_new_q;
                digit_new_q <= key_value;
            end
        end
    end

    assign kp.rows      = ~(4'b0001 << row_q);
    assign kp.digit_new = digit_new_q;
    assign kp.digit_old = digit_old_q;
    assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Bench for keypad_digit_capture: switch-closure keypad model, vector table, corner sequences, random presses.
module tb_keypad_digit_capture;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  cols_drv;

    keypad_digit_capture_if kp_if ();

    keypad_digit_capture #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A pressed key shorts its column low only while its row is driven low.
    always_comb begin
        cols_drv = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !kp_if.rows[r]) cols_drv[c] = 1'b0;
    end
    assign kp_if.cols = cols_drv;

    int   pulse_cnt  = 0;
    int   consec_err = 0;
    logic prev_kv    = 1'b0;

    always @(negedge clk) begin
        if (reset && kp_if.key_valid) pulse_cnt <= pulse_cnt + 1;
        if (kp_if.key_valid && prev_kv) consec_err <= consec_err + 1;
        prev_kv <= kp_if.key_valid;
    end

    int checks = 0;
    int fails  = 0;

    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] row_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct {
        int         key;
        int         hold;
        bit         bounce;
        int         exp_pulses;
        logic [3:0] exp_new;
        logic [3:0] exp_old;
    } vec_t;

    vec_t vecs [4];

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int         F_PULSES = 3;
    localparam logic [3:0] F_OLD    = 4'hF;
`else
    localparam int         F_PULSES = 1;
    localparam logic [3:0] F_OLD    = 4'h1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        int base;
        base = pulse_cnt;
        if (v.bounce) begin
            for (int i = 0; i < 2; i++) begin
                pressed[v.key] = 1'b1; wait_clk(5);
                pressed[v.key] = 1'b0; wait_clk(5);
            end
        end
        pressed[v.key] = 1'b1;
        wait_clk(v.hold);
        if (v.bounce) begin
            for (int i = 0; i < 2; i++) begin
                pressed[v.key] = 1'b0; wait_clk(5);
                pressed[v.key] = 1'b1; wait_clk(5);
            end
        end
        pressed[v.key] = 1'b0;
        wait_clk(40);
        check({name, "_pulses"}, pulse_cnt - base, v.exp_pulses);
        check({name, "_new"}, kp_if.digit_new, v.exp_new);
        check({name, "_old"}, kp_if.digit_old, v.exp_old);
    endtask

    initial begin
        int         base;
        int         k;
        int         hold;
        int         rel;
        logic [3:0] exp_new;
        logic [3:0] exp_old;

        vecs[0] = '{key: 6,  hold: 38,  bounce: 1'b0, exp_pulses: 1,        exp_new: 4'h6, exp_old: 4'h0};
        vecs[1] = '{key: 13, hold: 38,  bounce: 1'b0, exp_pulses: 1,        exp_new: 4'h0, exp_old: 4'h6};
        vecs[2] = '{key: 3,  hold: 38,  bounce: 1'b1, exp_pulses: 1,        exp_new: 4'hA, exp_old: 4'h0};
        vecs[3] = '{key: 14, hold: 100, bounce: 1'b0, exp_pulses: F_PULSES, exp_new: 4'hF, exp_old: F_OLD};

        pressed = '0;
        reset   = 1'b0;
        #12;
        check("reset_rows", kp_if.rows, 4'b1110);
        check("reset_new", kp_if.digit_new, 4'h0);
        check("reset_old", kp_if.digit_old, 4'h0);
        check("reset_kv", kp_if.key_valid, 1'b0);
        #10 reset = 1'b1;

        for (int n = 0; n < 20 && kp_if.rows == 4'b1110; n++) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan_rows_%0d", i), kp_if.rows, row_pat[(1 + i / 4) % 4]);
            @(negedge clk);
        end

        for (int i = 0; i < 3; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // "1" and "2" together on row 0 are ignored; releasing "2" leaves "1".
        base = pulse_cnt;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        wait_clk(60);
        check("multi_no_pulse", pulse_cnt - base, 0);
        pressed[1] = 1'b0;
        wait_clk(38);
        pressed[0] = 1'b0;
        wait_clk(40);
        check("multi_one_pulse", pulse_cnt - base, 1);
        check("multi_new", kp_if.digit_new, 4'h1);
        check("multi_old", kp_if.digit_old, 4'hA);

        apply_vec(vecs[3], "holdF");

        // Reset while "5" is held, then re-acceptance after release of reset.
        base = pulse_cnt;
        pressed[5] = 1'b1;
        for (int n = 0; n < 60 && pulse_cnt == base; n++) wait_clk(1);
        check("rst_held_pulse", pulse_cnt - base, 1);
        wait_clk(5);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_rows", kp_if.rows, 4'b1110);
        check("rst_mid_new", kp_if.digit_new, 4'h0);
        check("rst_mid_old", kp_if.digit_old, 4'h0);
        check("rst_mid_kv", kp_if.key_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_clk(1);
            check($sformatf("rst_low_kv_%0d", i), kp_if.key_valid, 1'b0);
        end
        reset = 1'b1;
        base = pulse_cnt;
        wait_clk(40);
        check("rst_reaccept_pulse", pulse_cnt - base, 1);
        check("rst_reaccept_new", kp_if.digit_new, 4'h5);
        check("rst_reaccept_old", kp_if.digit_old, 4'h0);
        pressed[5] = 1'b0;
        wait_clk(30);

        exp_new = 4'h5;
        for (int i = 0; i < 10; i++) begin
            k    = $urandom_range(15, 0);
            hold = 36 + $urandom_range(2, 0);
            rel  = 25 + $urandom_range(19, 0);
            exp_old = exp_new;
            exp_new = key_map[k];
            base = pulse_cnt;
            pressed[k] = 1'b1;
            wait_clk(hold);
            pressed[k] = 1'b0;
            wait_clk(rel);
            check($sformatf("rand%0d_pulses", i), pulse_cnt - base, 1);
            check($sformatf("rand%0d_new", i), kp_if.digit_new, exp_new);
            check($sformatf("rand%0d_old", i), kp_if.digit_old, exp_old);
        end

        check("no_back_to_back_kv", consec_err, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
